// File: rtl/fpga_dsp_pkg.sv
// Shared types for the FPGA-to-DSP link receiver: FSM states and the default beat layout.
package fpga_dsp_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} rx_state_e;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } link_beat_t;

endpackage

// File: rtl/fpga_dsp_fifo.sv
// Registered synchronous FIFO; head is the oldest entry, flushed by synchronous reset.
module fpga_dsp_fifo #(
   parameter int Width = 16,
   parameter int Depth = 4
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     push,
   input  logic [Width-1:0]         push_data,
   input  logic                     pop,
   output logic [Width-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CntW'(Depth));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + PtrW'(do_push);
      rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
      count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; emptiness is tracked by count_q alone.
   always_ff @(posedge Clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/fpga_to_dsp_receiver.sv
// DSP-side receiver: checks burst address sequence, buffers beats, streams them to the core.
module fpga_to_dsp_receiver
   import fpga_dsp_pkg::*;
#(
   parameter int AddrWidth = DEF_ADDR_W,
   parameter int DWidth    = DEF_DATA_W,
   parameter int Depth     = 4,
   parameter int LenWidth  = AddrWidth + 1
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Start,
   input  logic [AddrWidth-1:0] StartAddr,
   input  logic [LenWidth-1:0]  Len,
   input  logic                 InValid,
   input  logic [AddrWidth-1:0] InAddr,
   input  logic [DWidth-1:0]    InData,
   output logic                 InReady,
   output logic                 OutValid,
   output logic [AddrWidth-1:0] OutAddr,
   output logic [DWidth-1:0]    OutData,
   input  logic                 OutReady,
   output logic                 Busy,
   output logic                 Done,
   output logic                 SeqErr
);

   localparam int CntW = $clog2(Depth) + 1;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic [DWidth-1:0]    data;
   } beat_t;

   rx_state_e            state_q, state_d;
   logic [AddrWidth-1:0] exp_q, exp_d;
   logic [LenWidth-1:0]  len_q, len_d, cnt_q, cnt_d;
   logic                 seq_err_q, seq_err_d;
   logic                 push, pop, full, empty;
   logic [CntW-1:0]      fifo_cnt;
   beat_t                in_beat, head;

   assign in_beat = '{addr: InAddr, data: InData};

   fpga_dsp_fifo #(
      .Width (AddrWidth + DWidth),
      .Depth (Depth)
   ) u_fifo (
      .Clk       (Clk),
      .Rst       (Rst),
      .push      (push),
      .push_data (in_beat),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (fifo_cnt)
   );

   assign OutValid = !empty;
   assign pop      = OutValid && OutReady;
   assign OutAddr  = OutValid ? head.addr : '0;
   assign OutData  = OutValid ? head.data : '0;
   assign Busy     = (state_q != IDLE);
   assign Done     = (state_q == DONE);
   assign SeqErr   = seq_err_q;

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      seq_err_d = seq_err_q;
      InReady   = 1'b0;
      push      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               if (Len != '0) begin
                  len_d     = Len;
                  exp_d     = StartAddr;
                  cnt_d     = '0;
                  seq_err_d = 1'b0;
                  state_d   = RECV;
               end else begin
                  state_d   = DONE;
               end
            end
         end
         RECV: begin
            // No same-cycle pop bypass: a full FIFO stalls the link for a cycle.
            InReady = !full;
            if (InValid && !full) begin
               push = 1'b1;
               if (InAddr != exp_q) seq_err_d = 1'b1;
               exp_d = exp_q + AddrWidth'(1);
               cnt_d = cnt_q + LenWidth'(1);
               if (cnt_d == len_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (empty || (pop && fifo_cnt == CntW'(1))) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= IDLE;
         exp_q     <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         seq_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         seq_err_q <= seq_err_d;
      end
   end

endmodule

// File: doc/fpga_to_dsp_receiver.md
Name: fpga_to_dsp_receiver

Overview:
DSP-side responder for the FPGA-to-DSP address/data link. It accepts bursts of address/data beats driven by the FPGA address generator and checks that the addresses arrive in sequence. Beats are buffered in a small FIFO and presented to the DSP core over a valid/ready stream. It reports burst completion and sequence errors back to the FPGA side.

Parameters:
AddrWidth, 8, width of the link address bus.
DWidth, 8, width of the link data bus. Set to 16 for the wide-bus variant.
Depth, 4, FIFO entries (power of 2, >=2).
LenWidth, AddrWidth+1, width of the burst length. Allows up to 2^AddrWidth beats.

Ports:
Clk  input  1  link clock; all logic is on the rising edge.
Rst  input  1  synchronous, active-high reset.
Start  input  1  single-cycle burst start from the FPGA side.
StartAddr  input  AddrWidth  first expected address; sampled with Start.
Len  input  LenWidth  beats in the burst; sampled with Start.
InValid  input  1  link beat valid.
InAddr  input  AddrWidth  link beat address.
InData  input  DWidth  link beat data.
InReady  output  1  receiver can accept a beat this cycle.
OutValid  output  1  buffered beat available to the DSP core.
OutAddr  output  AddrWidth  address of the head beat.
OutData  output  DWidth  data of the head beat.
OutReady  input  1  DSP core consumes the head beat.
Busy  output  1  state is not IDLE.
Done  output  1  one-cycle pulse when a burst has fully drained.
SeqErr  output  1  sticky flag: an address mismatch occurred in the current or previous burst.

Behaviour:
- Clocking/reset: one clock, Clk. Rst is synchronous and active-high.
- Values held during reset: state=IDLE, FIFO empty, beat counter=0, InReady=0, OutValid=0, OutAddr=0, OutData=0, Busy=0, Done=0, SeqErr=0.
- FSM states: IDLE, RECV, DRAIN, DONE.
- IDLE:
  - On Start with Len!=0: latch Len and StartAddr into the expected-address register, clear SeqErr, then go to RECV.
  - On Start with Len==0: go to DONE, and Done pulses on the following cycle.
  - In any other state, Start is ignored and latched values do not change.
- RECV:
  - InReady = !full. A beat is accepted when InValid && InReady.
  - On acceptance:
    - push {InAddr, InData} into the FIFO;
    - if InAddr != expected, set SeqErr, but still store the beat;
    - increment expected modulo 2^AddrWidth (0xFF wraps to 0x00 at default width);
    - increment the beat counter.
  - When the accepted beat is beat number Len, go to DRAIN. InReady falls in the next cycle.
- DRAIN: InReady=0. Go to DONE when the FIFO is empty, including the case where the last pop happens this cycle.
- DONE: Done=1 for exactly one cycle, then IDLE. SeqErr holds its value until the next accepted Start.
- Busy = (state != IDLE).
- FIFO:
  - Registered. A beat accepted in cycle N is visible on OutValid/OutAddr/OutData in cycle N+1 at the earliest.
  - Pop when OutValid && OutReady.
  - Push and pop in the same cycle are both performed, and the count is unchanged.
  - InReady is computed from the registered full flag, with no same-cycle pop bypass. When the FIFO is full, InReady=0 even if a pop occurs.
  - Pointers are log2(Depth) bits and wrap naturally. Count is log2(Depth)+1 bits.
  - OutAddr/OutData always reflect the head entry. Their value is don't-care when OutValid=0.
- InValid outside RECV is ignored and nothing is stored.
- Rst during a burst: the FIFO is flushed, the FSM returns to IDLE, and no Done pulse is produced.

Decomposition:
- Package fpga_dsp_pkg holds:
  - the state enum rx_state_e {IDLE, RECV, DRAIN, DONE};
  - the typedef link_beat_t, a packed {addr, data} struct parameterised through localparams DEF_ADDR_W=8 and DEF_DATA_W=8.
- One sub-module, fpga_dsp_fifo: parameterised synchronous FIFO (Width, Depth) with push/pop/full/empty/head outputs.

Test Plan:
- Basic burst: Start with StartAddr=0x10 and Len=3; beats at 0x10, 0x11, 0x12 with data 0xA1, 0xA2, 0xA3; OutReady=1 → three OutValid beats in order, each one cycle after its accept. Done pulses once and SeqErr=0.
- Backpressure: Depth=4, Len=6, OutReady=0 → InReady drops after 4 accepts. Raising OutReady for 1 cycle pops 0x10, and InReady returns next cycle. All 6 beats are delivered and Done fires after the last pop.
- Wrap and error: StartAddr=0xFE, Len=3, addrs 0xFE, 0xFF, 0x00 → SeqErr=0. Repeating with addrs 0xFE, 0xFF, 0x05 → SeqErr=1 and the 0x05 beat is still delivered.
- Len=0 and ignored Start: Start with Len=0 → no InReady, Done one cycle after DONE entry. Start asserted during RECV → no change to expected address or count.
- Mid-burst reset: Rst after 2 of 4 beats → next cycle OutValid=0, Busy=0, SeqErr=0, no Done. A fresh burst then works normally.
- Wide bus: DWidth=16, data 0xBEEF, 0x1234 → OutData matches bit-exactly.
